hw_dispatch_flex: RTL and testbench

HW_DISPATCH_FLEX -- requirements
Module: hw_dispatch_flex

---
 rtl/hw_dispatch_pkg.sv | 7 +
 rtl/hw_dispatch_rd_port.sv | 47 ++++
 rtl/hw_dispatch_flex.sv | 89 ++++++++
 tb/tb_hw_dispatch_flex.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hw_dispatch_pkg.sv
// hw_dispatch_pkg: write-target encodings and the per-core read FSM states.
package hw_dispatch_pkg;
    localparam logic [1:0] DISP_PUSH  = 2'd0;
    localparam logic [1:0] DISP_CONF  = 2'd1;
    localparam logic [1:0] DISP_FLUSH = 2'd2;
    typedef enum logic {RD_IDLE, RD_WAIT} rd_state_e;
endpackage

// File: rtl/hw_dispatch_rd_port.sv
// hw_dispatch_rd_port: one core's read pointer and request FSM.
module hw_dispatch_rd_port
    import hw_dispatch_pkg::*;
#(
    parameter int PW = 3
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          pop_req,
    input  logic          pop_ack,
    input  logic          slot_bit,
    input  logic          flush,
    input  logic [PW-1:0] wptr,
    output logic [PW-1:0] rptr,
    output logic          dispatch_event,
    output logic          clr
);
    rd_state_e state_q, state_d;
    logic [PW-1:0] rptr_d;
    logic active;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= RD_IDLE;
            rptr    <= '0;
        end else begin
            state_q <= state_d;
            rptr    <= rptr_d;
        end
    end
    always_comb begin
        active         = state_q == RD_WAIT || pop_req;
        dispatch_event = active && slot_bit;
        clr            = state_q == RD_WAIT && dispatch_event && pop_ack;
        state_d        = state_q;
        rptr_d         = rptr;
        // a flush rewinds the pointer but leaves an outstanding request in place
        if (flush) begin
            rptr_d = '0;
        end else if (clr) begin
            state_d = RD_IDLE;
            rptr_d  = rptr + PW'(1);
        end else begin
            if (pop_req) state_d = RD_WAIT;
            if (active && !slot_bit && rptr != wptr) rptr_d = rptr + PW'(1);
        end
    end
endmodule

// File: rtl/hw_dispatch_flex.sv
// hw_dispatch_flex: multi-core dispatch FIFO with per-slot team masks and a single arbitrated write port.
module hw_dispatch_flex
    import hw_dispatch_pkg::*;
#(
    parameter int NB_CORES   = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic [NB_CORES-1:0]                  pop_req_i,
    input  logic [NB_CORES-1:0]                  pop_ack_i,
    output logic [NB_CORES-1:0][DATA_WIDTH-1:0]  dispatch_value_o,
    output logic [NB_CORES-1:0]                  dispatch_event_o,
    input  logic [NB_CORES-1:0]                  w_req_i,
    input  logic [NB_CORES-1:0][DATA_WIDTH-1:0]  w_data_i,
    input  logic [NB_CORES-1:0][1:0]             reg_sel_i,
    output logic [NB_CORES-1:0]                  w_gnt_o,
    output logic                                 full_o,
    output logic                                 empty_o
);
    localparam int PW = $clog2(FIFO_DEPTH);
    logic [FIFO_DEPTH-1:0][DATA_WIDTH-1:0] data_q;
    logic [FIFO_DEPTH-1:0][NB_CORES-1:0]   mask_q, mask_d;
    logic [NB_CORES-1:0]                   conf_q;
    logic [PW-1:0]                         wptr_q;
    logic [NB_CORES-1:0][PW-1:0]           rptr;
    logic [NB_CORES-1:0]                   clr, slot_bit, win_oh;
    logic [1:0]                            sel;
    logic [DATA_WIDTH-1:0]                 wdata;
    logic                                  any, accept, do_push, flush;
    // isolate the lowest-index requester; sel/wdata are a one-hot OR-mux
    assign win_oh = w_req_i & (~w_req_i + NB_CORES'(1));
    always_comb begin
        sel   = '0;
        wdata = '0;
        for (int i = 0; i < NB_CORES; i++) begin
            sel   = sel | (win_oh[i] ? reg_sel_i[i] : 2'b00);
            wdata = wdata | (win_oh[i] ? w_data_i[i] : '0);
        end
    end
    assign any     = |w_req_i;
    assign accept  = any && rst_ni && (sel != DISP_PUSH || conf_q == '0 || mask_q[wptr_q] == '0);
    assign do_push = accept && sel == DISP_PUSH && conf_q != '0;
    assign flush   = accept && sel == DISP_FLUSH;
    assign w_gnt_o = accept ? win_oh : '0;
    assign full_o  = |mask_q[wptr_q];
    assign empty_o = mask_q == '0;
    // acks only hit slots with a set bit, so they never collide with the free push slot
    always_comb begin
        mask_d = mask_q;
        for (int c = 0; c < NB_CORES; c++)
            if (clr[c]) mask_d[rptr[c]][c] = 1'b0;
        if (do_push) mask_d[wptr_q] = conf_q;
        if (flush) mask_d = '0;
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q <= '0;
            mask_q <= '0;
            conf_q <= '0;
            wptr_q <= '0;
        end else begin
            mask_q <= mask_d;
            if (do_push) begin
                data_q[wptr_q] <= wdata;
                wptr_q         <= wptr_q + PW'(1);
            end
            if (accept && sel == DISP_CONF) conf_q <= wdata[NB_CORES-1:0];
            if (flush) wptr_q <= '0;
        end
    end
    for (genvar c = 0; c < NB_CORES; c++) begin : g_rd
        assign slot_bit[c]         = mask_q[rptr[c]][c];
        assign dispatch_value_o[c] = data_q[rptr[c]];
        hw_dispatch_rd_port #(.PW(PW)) u_rd (
            .clk_i          (clk_i),
            .rst_ni         (rst_ni),
            .pop_req        (pop_req_i[c]),
            .pop_ack        (pop_ack_i[c]),
            .slot_bit       (slot_bit[c]),
            .flush          (flush),
            .wptr           (wptr_q),
            .rptr           (rptr[c]),
            .dispatch_event (dispatch_event_o[c]),
            .clr            (clr[c])
        );
    end
endmodule

// File: tb/tb_hw_dispatch_flex.sv
// tb_hw_dispatch_flex: directed scenarios checked against a slot/queue model every cycle.
module tb_hw_dispatch_flex;
    localparam int NC = 4;
    localparam int D  = 8;
    localparam int W  = 32;
    logic clk, rst_n;
    logic [NC-1:0] pop_req, pop_ack, dispatch_event, w_req, w_gnt;
    logic [NC-1:0][W-1:0] dispatch_value, w_data;
    logic [NC-1:0][1:0] reg_sel;
    logic full, empty;
    int n_tests = 0;
    int n_fail  = 0;

    hw_dispatch_flex #(.NB_CORES(NC), .FIFO_DEPTH(D), .DATA_WIDTH(W)) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .pop_req_i        (pop_req),
        .pop_ack_i        (pop_ack),
        .dispatch_value_o (dispatch_value),
        .dispatch_event_o (dispatch_event),
        .w_req_i          (w_req),
        .w_data_i         (w_data),
        .reg_sel_i        (reg_sel),
        .w_gnt_o          (w_gnt),
        .full_o           (full),
        .empty_o          (empty)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    // model: slot ring with pending masks, per-core read slot and outstanding-request flag
    bit [W-1:0]  md [D];
    bit [NC-1:0] mm [D];
    bit [NC-1:0] mconf;
    int          mw;
    int          mr [NC];
    bit          mwait [NC];

    task automatic lit(string name, logic [63:0] got, logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int winner();
        for (int c = 0; c < NC; c++) if (w_req[c]) return c;
        return -1;
    endfunction

    function automatic logic [NC-1:0] exp_ev();
        logic [NC-1:0] e;
        for (int c = 0; c < NC; c++) e[c] = (mwait[c] || pop_req[c]) && mm[mr[c]][c];
        return e;
    endfunction

    function automatic logic [NC-1:0] exp_gnt();
        int k = winner();
        if (!rst_n || k < 0) return '0;
        if (reg_sel[k] == 2'd0 && mconf != 0 && mm[mw] != 0) return '0;
        return NC'(1) << k;
    endfunction

    function automatic bit exp_empty();
        for (int i = 0; i < D; i++) if (mm[i] != 0) return 0;
        return 1;
    endfunction

    task automatic step();
        logic [NC-1:0] ev, g;
        bit ow [NC];
        int k;
        if (!rst_n) begin
            for (int i = 0; i < D; i++) begin md[i] = 0; mm[i] = 0; end
            for (int c = 0; c < NC; c++) begin mr[c] = 0; mwait[c] = 0; end
            mconf = 0;
            mw = 0;
            return;
        end
        ev = exp_ev();
        g  = exp_gnt();
        k  = winner();
        ow = mwait;
        for (int c = 0; c < NC; c++) begin
            if (mwait[c] && ev[c] && pop_ack[c]) begin
                mm[mr[c]][c] = 0;
                mr[c] = (mr[c] + 1) % D;
                mwait[c] = 0;
            end else begin
                if ((mwait[c] || pop_req[c]) && !ev[c] && mr[c] != mw) mr[c] = (mr[c] + 1) % D;
                if (pop_req[c]) mwait[c] = 1;
            end
        end
        if (k >= 0 && g[k]) begin
            case (reg_sel[k])
                2'd0: if (mconf != 0) begin
                    md[mw] = w_data[k];
                    mm[mw] = mconf;
                    mw = (mw + 1) % D;
                end
                2'd1: mconf = w_data[k][NC-1:0];
                2'd2: begin
                    for (int i = 0; i < D; i++) mm[i] = 0;
                    for (int c = 0; c < NC; c++) mr[c] = 0;
                    mw = 0;
                    mwait = ow;
                end
                default: ;
            endcase
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        step();
    end

    initial forever begin
        @(negedge clk);
        lit("event", dispatch_event, exp_ev());
        lit("w_gnt", w_gnt, exp_gnt());
        lit("full", full, mm[mw] != 0);
        lit("empty", empty, exp_empty());
        for (int c = 0; c < NC; c++) lit($sformatf("value%0d", c), dispatch_value[c], md[mr[c]]);
    end

    task automatic wr(int c, logic [1:0] s, logic [W-1:0] d);
        int n = 0;
        w_req[c] = 1; reg_sel[c] = s; w_data[c] = d;
        @(negedge clk);
        while (!w_gnt[c] && n < 50) begin @(negedge clk); n++; end
        lit("write grant wait", w_gnt[c], 1);
        @(posedge clk); #1;
        w_req[c] = 0;
    endtask

    task automatic pop(int c, logic [W-1:0] exp);
        int n = 0;
        pop_req[c] = 1;
        @(negedge clk);
        while (!dispatch_event[c] && n < 50) begin @(negedge clk); n++; end
        lit($sformatf("pop%0d event", c), dispatch_event[c], 1);
        lit($sformatf("pop%0d value", c), dispatch_value[c], exp);
        @(posedge clk); #1;
        pop_req[c] = 0; pop_ack[c] = 1;
        @(posedge clk); #1;
        pop_ack[c] = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        pop_req = 0; pop_ack = 0; w_req = 0; reg_sel = '0; w_data = '0; rst_n = 0;
        w_req[2] = 1; pop_req = 4'hF;
        repeat (2) @(negedge clk);
        lit("reset gnt", w_gnt, 0);
        lit("reset event", dispatch_event, 0);
        lit("reset empty", empty, 1);
        lit("reset full", full, 0);
        lit("reset value0", dispatch_value[0], 0);
        @(posedge clk); #1;
        w_req = 0; pop_req = 0; rst_n = 1;

        wr(0, 2'd0, 32'hDEAD);
        wr(1, 2'd3, 32'h0);
        @(negedge clk);
        lit("conf0 push dropped", empty, 1);
        @(posedge clk); #1;

        // team 0101, one push
        wr(0, 2'd1, 32'h5);
        wr(0, 2'd0, 32'hA5);
        pop_req = 4'hF;
        @(negedge clk);
        lit("team event", dispatch_event, 4'b0101);
        lit("team value0", dispatch_value[0], 32'hA5);
        lit("team value2", dispatch_value[2], 32'hA5);
        lit("team pending", empty, 0);
        @(posedge clk); #1;
        pop_req = 0; pop_ack = 4'b0101;
        @(posedge clk); #1;
        pop_ack = 0;
        @(negedge clk);
        lit("team freed", empty, 1);
        @(posedge clk); #1;

        // fill to full, ninth push waits for one ack
        wr(0, 2'd1, 32'h1);
        for (int i = 0; i < 8; i++) wr(1, 2'd0, 32'h100 + i);
        @(negedge clk);
        lit("full after 8", full, 1);
        @(posedge clk); #1;
        w_req[1] = 1; reg_sel[1] = 2'd0; w_data[1] = 32'h108;
        pop_req[0] = 1;
        @(negedge clk);
        lit("9th blocked", w_gnt, 0);
        lit("full head value", dispatch_value[0], 32'h100);
        @(posedge clk); #1;
        pop_req[0] = 0; pop_ack[0] = 1;
        @(negedge clk);
        lit("9th blocked in ack cycle", w_gnt, 0);
        @(posedge clk); #1;
        pop_ack[0] = 0;
        @(negedge clk);
        lit("9th granted after ack", w_gnt, 4'b0010);
        @(posedge clk); #1;
        w_req = 0;
        for (int i = 1; i < 9; i++) pop(0, 32'h100 + i);

        // simultaneous writers: lower index first
        w_req = 4'b1010; reg_sel = '0; w_data[1] = 32'h31; w_data[3] = 32'h33;
        @(negedge clk);
        lit("arb first", w_gnt, 4'b0010);
        @(posedge clk); #1;
        w_req[1] = 0;
        @(negedge clk);
        lit("arb second", w_gnt, 4'b1000);
        @(posedge clk); #1;
        w_req = 0;
        pop(0, 32'h31);
        pop(0, 32'h33);

        // core 2 skips three slots it is not part of
        wr(0, 2'd2, 32'h0);
        wr(0, 2'd1, 32'h1);
        wr(0, 2'd0, 32'h41);
        wr(0, 2'd0, 32'h42);
        wr(0, 2'd0, 32'h43);
        wr(0, 2'd1, 32'h5);
        wr(0, 2'd0, 32'h44);
        pop_req[2] = 1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            lit($sformatf("skip event c%0d", k), dispatch_event[2], k == 3);
            if (k == 3) lit("skip value", dispatch_value[2], 32'h44);
            @(posedge clk); #1;
        end
        pop_req[2] = 0; pop_ack[2] = 1;
        @(posedge clk); #1;
        pop_ack[2] = 0;

        // flush with five pending and core 0 waiting
        wr(0, 2'd0, 32'h45);
        pop_req[0] = 1;
        @(negedge clk);
        lit("pre-flush event", dispatch_event[0], 1);
        @(posedge clk); #1;
        pop_req[0] = 0;
        wr(1, 2'd2, 32'h0);
        @(negedge clk);
        lit("flush empty", empty, 1);
        lit("flush event", dispatch_event[0], 0);
        lit("flush full", full, 0);
        @(posedge clk); #1;
        wr(1, 2'd0, 32'hE0);
        @(negedge clk);
        lit("post-flush event", dispatch_event[0], 1);
        lit("post-flush value", dispatch_value[0], 32'hE0);
        @(posedge clk); #1;
        pop_ack[0] = 1;
        @(posedge clk); #1;
        pop_ack[0] = 0;
        pop(2, 32'hE0);

        // wrap-around stream
        wr(0, 2'd1, 32'h1);
        for (int i = 0; i < 20; i++) begin
            wr(3, 2'd0, 32'h600 + i);
            pop(0, 32'h600 + i);
        end

        // reset mid-transaction
        wr(0, 2'd0, 32'h77);
        pop_req[0] = 1;
        @(negedge clk);
        lit("abort pre event", dispatch_event[0], 1);
        @(posedge clk); #1;
        pop_req[0] = 0;
        rst_n = 0;
        @(negedge clk);
        lit("abort event", dispatch_event, 0);
        lit("abort empty", empty, 1);
        @(posedge clk); #1;
        rst_n = 1;
        @(negedge clk);
        lit("abort after release", dispatch_event, 0);
        @(posedge clk); #1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
